if_fetch_unit: RTL and testbench

- Instruction-fetch front end that produces the IF/ID register inputs: PC+4, instruction and flush.
- Owns the PC register and next-PC selection: sequential, branch, jump or exception vector.
- Drives a variable-latency instruction-memory request/ready handshake.
- Presents one instruction per delivery to IF/ID and inserts bubbles on memory wait, redirect and discard.

---
 rtl/if_fetch_unit_if.sv | 10 +
 rtl/if_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction-memory request/ready handshake bundle
interface if_fetch_unit_if;
  logic        OMemReq;
  logic [31:0] OMemAddr;
  logic        IMemReady;
  logic [31:0] IMemRdata;

  modport master (output OMemReq, OMemAddr, input IMemReady, IMemRdata);
  modport slave  (input OMemReq, OMemAddr, output IMemReady, IMemRdata);
endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch front end: PC, next-PC select, imem handshake, IF/ID feed
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0008
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   IStall,
  input  logic                   IBranch,
  input  logic [31:0]            IBranchTarget,
  input  logic                   IJump,
  input  logic [31:0]            IJumpTarget,
  input  logic                   IExc,
  if_fetch_unit_if.master        mem,
  output logic [31:0]            OPC,
  output logic [31:0]            OPCAdd4,
  output logic [31:0]            OInst,
  output logic                   OValid,
  output logic                   OFlush
);

  typedef enum logic [1:0] {BOOT, FETCH, STALL, DRAIN} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] req_addr, req_n;
  logic [31:0] hold_buf, buf_n;
  logic        mem_req, mem_req_n;
  logic [31:0] opc_n, opc4_n, inst_n;
  logic        valid_n;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_inc;

  assign redirect     = IExc | IBranch | IJump;
  assign OFlush       = redirect;
  assign pc_inc       = pc + 32'd4;
  assign mem.OMemReq  = mem_req;
  assign mem.OMemAddr = req_addr;

  always_comb begin
    target = IJumpTarget;
    if (IExc)         target = EXC_VECTOR;
    else if (IBranch) target = IBranchTarget;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= BOOT;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      BOOT:  state_n = FETCH;
      FETCH: begin
        if (mem.IMemReady) state_n = (!redirect && IStall) ? STALL : FETCH;
        else if (redirect) state_n = DRAIN;
      end
      STALL: if (redirect || !IStall) state_n = FETCH;
      DRAIN: if (mem.IMemReady) state_n = FETCH;
      default: state_n = BOOT;
    endcase
  end

  // Next values of PC, request address, hold buffer and the IF/ID outputs.
  always_comb begin
    pc_n    = pc;
    req_n   = req_addr;
    buf_n   = hold_buf;
    opc_n   = OPC;
    opc4_n  = OPCAdd4;
    inst_n  = OInst;
    valid_n = OValid;
    case (state)
      BOOT: begin
        if (redirect) begin
          pc_n  = target;
          req_n = target;
        end
      end
      FETCH: begin
        if (mem.IMemReady) begin
          if (redirect) begin
            pc_n = target; req_n = target;
            opc_n = '0; opc4_n = '0; inst_n = '0; valid_n = 1'b0;
          end else if (IStall) begin
            buf_n = mem.IMemRdata;
          end else begin
            opc_n = pc; opc4_n = pc_inc; inst_n = mem.IMemRdata; valid_n = 1'b1;
            pc_n = pc_inc; req_n = pc_inc;
          end
        end else if (redirect) begin
          pc_n = target;
          opc_n = '0; opc4_n = '0; inst_n = '0; valid_n = 1'b0;
        end else if (!IStall) begin
          opc_n = '0; opc4_n = '0; inst_n = '0; valid_n = 1'b0;
        end
      end
      STALL: begin
        if (redirect) begin
          pc_n = target; req_n = target; buf_n = '0;
          opc_n = '0; opc4_n = '0; inst_n = '0; valid_n = 1'b0;
        end else if (!IStall) begin
          opc_n = pc; opc4_n = pc_inc; inst_n = hold_buf; valid_n = 1'b1;
          pc_n = pc_inc; req_n = pc_inc; buf_n = '0;
        end
      end
      DRAIN: begin
        // The old request is still on the bus; only PC tracks redirects here.
        opc_n = '0; opc4_n = '0; inst_n = '0; valid_n = 1'b0;
        if (redirect) pc_n = target;
        if (mem.IMemReady) req_n = redirect ? target : pc;
      end
      default: ;
    endcase
    mem_req_n = (state_n == FETCH) || (state_n == DRAIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      hold_buf <= '0;
      mem_req  <= 1'b0;
      OPC      <= '0;
      OPCAdd4  <= '0;
      OInst    <= '0;
      OValid   <= 1'b0;
    end else begin
      pc       <= pc_n;
      req_addr <= req_n;
      hold_buf <= buf_n;
      mem_req  <= mem_req_n;
      OPC      <= opc_n;
      OPCAdd4  <= opc4_n;
      OInst    <= inst_n;
      OValid   <= valid_n;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit against a transaction-level model
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic        IStall, IBranch, IJump, IExc;
  logic [31:0] IBranchTarget, IJumpTarget;
  logic [31:0] OPC, OPCAdd4, OInst;
  logic        OValid, OFlush;

  always #5 clk = ~clk;

  if_fetch_unit_if mem_if();
  assign mem_if.IMemRdata = mem_if.OMemAddr + 32'd1;

  if_fetch_unit #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
    .clk(clk), .reset(reset), .IStall(IStall),
    .IBranch(IBranch), .IBranchTarget(IBranchTarget),
    .IJump(IJump), .IJumpTarget(IJumpTarget), .IExc(IExc),
    .mem(mem_if), .OPC(OPC), .OPCAdd4(OPCAdd4), .OInst(OInst),
    .OValid(OValid), .OFlush(OFlush)
  );

  int checks = 0;
  int failures = 0;

  // Model: booting flag, an outstanding request that may be stale, and an optional parked word.
  bit          m_booting, m_req_on, m_stale, m_parked;
  logic [31:0] m_pc, m_addr, m_park;
  logic [31:0] m_opc, m_opc4, m_inst;
  bit          m_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_booting = 1; m_req_on = 0; m_stale = 0; m_parked = 0;
    m_pc = RESET_PC; m_addr = RESET_PC; m_park = '0;
    m_opc = '0; m_opc4 = '0; m_inst = '0; m_valid = 0;
  endtask

  task automatic bubble();
    m_opc = '0; m_opc4 = '0; m_inst = '0; m_valid = 0;
  endtask

  task automatic deliver(input logic [31:0] word);
    m_opc = m_pc; m_opc4 = m_pc + 32'd4; m_inst = word; m_valid = 1;
    m_pc = m_pc + 32'd4; m_addr = m_pc;
  endtask

  task automatic model_edge(input bit rdy, input bit st, input bit exc, input bit br, input bit jmp,
                            input logic [31:0] bt, input logic [31:0] jt);
    bit          redir;
    logic [31:0] tgt;
    logic [31:0] word;
    redir = exc | br | jmp;
    tgt   = exc ? EXC_VECTOR : (br ? bt : jt);
    word  = m_addr + 32'd1;
    if (m_booting) begin
      m_booting = 0; m_req_on = 1;
      if (redir) begin m_pc = tgt; m_addr = tgt; end
    end else if (m_parked) begin
      if (redir) begin
        m_parked = 0; m_req_on = 1; m_pc = tgt; m_addr = tgt; bubble();
      end else if (!st) begin
        m_parked = 0; m_req_on = 1; deliver(m_park);
      end
    end else if (m_stale) begin
      bubble();
      if (redir) m_pc = tgt;
      if (rdy) begin m_stale = 0; m_addr = m_pc; end
    end else if (rdy) begin
      if (redir) begin
        m_pc = tgt; m_addr = tgt; bubble();
      end else if (st) begin
        m_park = word; m_parked = 1; m_req_on = 0;
      end else begin
        deliver(word);
      end
    end else if (redir) begin
      m_pc = tgt; m_stale = 1; bubble();
    end else if (!st) begin
      bubble();
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".OMemReq"},  {31'd0, mem_if.OMemReq}, {31'd0, m_req_on});
    chk({tag, ".OMemAddr"}, mem_if.OMemAddr, m_addr);
    chk({tag, ".OPC"},      OPC,     m_opc);
    chk({tag, ".OPCAdd4"},  OPCAdd4, m_opc4);
    chk({tag, ".OInst"},    OInst,   m_inst);
    chk({tag, ".OValid"},   {31'd0, OValid}, {31'd0, m_valid});
  endtask

  task automatic step(input string tag, input bit rdy, input bit st, input bit exc, input bit br,
                      input bit jmp, input logic [31:0] bt, input logic [31:0] jt);
    mem_if.IMemReady = rdy; IStall = st; IExc = exc; IBranch = br; IJump = jmp;
    IBranchTarget = bt; IJumpTarget = jt;
    #1;
    chk({tag, ".OFlush"}, {31'd0, OFlush}, {31'd0, exc | br | jmp});
    @(posedge clk);
    model_edge(rdy, st, exc, br, jmp, bt, jt);
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 0; IStall = 0; IBranch = 0; IJump = 0; IExc = 0;
    IBranchTarget = '0; IJumpTarget = '0; mem_if.IMemReady = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1;

    step("boot", 1, 0, 0, 0, 0, 0, 0);
    step("seq0", 1, 0, 0, 0, 0, 0, 0);
    chk("first_inst", OInst, 32'd1);
    step("seq1", 1, 0, 0, 0, 0, 0, 0);
    step("seq2", 1, 0, 0, 0, 0, 0, 0);
    chk("third_inst", OInst, 32'd9);
    step("seq3", 1, 0, 0, 0, 0, 0, 0);
    chk("addr_0x10", mem_if.OMemAddr, 32'h10);

    for (int i = 0; i < 3; i++) step("wait", 0, 0, 0, 0, 0, 0, 0);
    step("late", 1, 0, 0, 0, 0, 0, 0);
    chk("late_inst", OInst, 32'h11);

    step("br_pend", 0, 0, 0, 1, 0, 32'h40, 0);
    step("drain", 0, 0, 0, 0, 0, 0, 0);
    step("drain_rdy", 1, 0, 0, 0, 0, 0, 0);
    chk("after_drain_addr", mem_if.OMemAddr, 32'h40);
    step("br_fetch", 1, 0, 0, 0, 0, 0, 0);

    step("all_redir", 1, 0, 1, 1, 1, 32'h200, 32'h300);
    chk("exc_vector", mem_if.OMemAddr, EXC_VECTOR);
    step("jmp1c", 1, 0, 0, 0, 1, 0, 32'h1C);
    step("at1c", 1, 0, 0, 0, 0, 0, 0);
    step("stall0", 1, 1, 0, 0, 0, 0, 0);
    step("stall1", 0, 1, 0, 0, 0, 0, 0);
    step("unstall", 0, 0, 0, 0, 0, 0, 0);
    chk("unstall_inst", OInst, 32'h21);
    step("resume", 1, 0, 0, 0, 0, 0, 0);

    step("jmp_top", 1, 0, 0, 0, 1, 0, 32'hFFFF_FFFC);
    step("wrap", 1, 0, 0, 0, 0, 0, 0);
    chk("wrap_pc4", OPCAdd4, 32'h0);

    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom % 3) != 0, ($urandom % 5) == 0, ($urandom % 23) == 0,
           ($urandom % 11) == 0, ($urandom % 9) == 0,
           $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC);
    end

    step("pre_drain", 1, 0, 0, 0, 0, 0, 0);
    step("to_drain", 0, 0, 0, 1, 0, 32'h100, 0);
    #2;
    reset = 0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    reset = 1;
    step("reboot", 1, 0, 0, 0, 0, 0, 0);
    step("refetch", 1, 0, 0, 0, 0, 0, 0);
    chk("refetch_inst", OInst, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
